vgaconsole_term_ctrl: RTL and testbench



---
 rtl/vgaconsole_term_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_vgaconsole_term_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vgaconsole_term_ctrl.sv
// Terminal sequencer for the VGA text console: decodes a byte stream into
// cursor movement and text buffer writes, and walks the buffer one cell per
// cycle for scroll-up and clear-screen.
//
// Handshake: a byte transfers on any rising edge where in_valid and in_ready
// are both high; in_valid may be held across stalls and in_data must be
// stable while in_valid is high. in_ready is high only in IDLE with no
// write stuck waiting on buf_gnt.
module vgaconsole_term_ctrl #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 10,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [1:0]        color,
    input  logic              buf_gnt,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [8:0]        buf_wdata,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [8:0]        buf_rdata,
    output logic [1:0]        cur_row,
    output logic [3:0]        cur_col,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(NUM_COLS);
    localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'(NUM_COLS * (NUM_ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] LINE_BASE = ADDR_W'(NUM_COLS * (NUM_ROWS - 1));
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(NUM_COLS * NUM_ROWS - 1);
    localparam logic [3:0]        LAST_COL  = 4'(NUM_COLS - 1);
    localparam logic [1:0]        LAST_ROW  = 2'(NUM_ROWS - 1);
    localparam logic [8:0]        BLANK     = {2'b00, 7'h20};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCROLL,
        S_CLEAR_LINE,
        S_CLEAR_ALL
    } state_t;

    state_t            state, state_n;
    logic [1:0]        row_n;
    logic [3:0]        col_n;
    logic [ADDR_W-1:0] k, k_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [8:0]        wdata_n;

    logic              stall;
    logic              accept;
    logic [6:0]        ch;
    logic [ADDR_W-1:0] cell_addr;
    logic              unused_bit7;

    // The ASCII decode only looks at the low seven bits.
    assign ch          = in_data[6:0];
    assign unused_bit7 = in_data[7];

    // A registered write that the host is holding off freezes the whole block.
    assign stall     = buf_we & ~buf_gnt;
    assign in_ready  = ~rst & (state == S_IDLE) & ~stall;
    assign accept    = in_valid & in_ready;
    assign busy      = (state != S_IDLE) | buf_we;
    assign cell_addr = ADDR_W'(cur_row) * COLS_A + ADDR_W'(cur_col);

    // Scroll reads one row ahead of the cell it is about to overwrite.
    assign buf_raddr = (state == S_SCROLL) ? k + COLS_A : '0;

    // Next-state, cursor, walk counter and write-port values.
    always_comb begin
        state_n = state;
        row_n   = cur_row;
        col_n   = cur_col;
        k_n     = k;
        we_n    = 1'b0;
        addr_n  = buf_addr;
        wdata_n = buf_wdata;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (ch >= 7'h20 && ch <= 7'h7E) begin
                        we_n    = 1'b1;
                        addr_n  = cell_addr;
                        wdata_n = {color, ch};
                        if (cur_col < LAST_COL) begin
                            col_n = cur_col + 4'd1;
                        end else begin
                            col_n = '0;
                            if (cur_row < LAST_ROW) begin
                                row_n = cur_row + 2'd1;
                            end else begin
                                state_n = S_SCROLL;
                                k_n     = '0;
                            end
                        end
                    end else begin
                        case (ch)
                            7'h0A: begin
                                col_n = '0;
                                if (cur_row < LAST_ROW) begin
                                    row_n = cur_row + 2'd1;
                                end else begin
                                    state_n = S_SCROLL;
                                    k_n     = '0;
                                end
                            end
                            7'h0D: col_n = '0;
                            7'h08: begin
                                if (cur_col != 4'd0) col_n = cur_col - 4'd1;
                            end
                            7'h0C: begin
                                state_n = S_CLEAR_ALL;
                                k_n     = '0;
                                row_n   = '0;
                                col_n   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_SCROLL: begin
                we_n    = 1'b1;
                addr_n  = k;
                wdata_n = buf_rdata;
                if (k == COPY_LAST) begin
                    state_n = S_CLEAR_LINE;
                    k_n     = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            S_CLEAR_LINE: begin
                we_n    = 1'b1;
                addr_n  = LINE_BASE + k;
                wdata_n = BLANK;
                if (k == LINE_LAST) begin
                    state_n = S_IDLE;
                    k_n     = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            S_CLEAR_ALL: begin
                we_n    = 1'b1;
                addr_n  = k;
                wdata_n = BLANK;
                if (k == CELL_LAST) begin
                    state_n = S_IDLE;
                    k_n     = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                k_n     = '0;
            end
        endcase
    end

    // State register and write-port registers; everything holds during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_row   <= '0;
            cur_col   <= '0;
            k         <= '0;
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
        end else if (!stall) begin
            state     <= state_n;
            cur_row   <= row_n;
            cur_col   <= col_n;
            k         <= k_n;
            buf_we    <= we_n;
            buf_addr  <= addr_n;
            buf_wdata <= wdata_n;
        end
    end
endmodule

// File: tb/tb_vgaconsole_term_ctrl.sv
// Directed bench for vgaconsole_term_ctrl: decode vectors from a table, then
// hand-written scroll, clear, grant-stall and reset-abort sequences. A
// behavioural text buffer answers reads and records writes.
module tb_vgaconsole_term_ctrl;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [1:0] color;
    logic       buf_gnt;
    logic       buf_we;
    logic [4:0] buf_addr;
    logic [8:0] buf_wdata;
    logic [4:0] buf_raddr;
    logic [8:0] buf_rdata;
    logic [1:0] cur_row;
    logic [3:0] cur_col;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    bit sb_on  = 1'b1;

    logic [13:0] exp_q[$];
    logic [8:0]  mem [0:31];
    logic [8:0]  scr [0:29];

    typedef struct {
        logic [7:0] b;
        logic [1:0] c;
        logic       we;
        logic [4:0] addr;
        logic [8:0] wdata;
        logic [1:0] row;
        logic [3:0] col;
    } vec_t;

    vec_t vecs [18];

    vgaconsole_term_ctrl #(.NUM_ROWS(3), .NUM_COLS(10), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .color     (color),
        .buf_gnt   (buf_gnt),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata),
        .buf_raddr (buf_raddr),
        .buf_rdata (buf_rdata),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .busy      (busy)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Text buffer: combinational read, write on a granted edge.
    assign buf_rdata = mem[buf_raddr];
    always @(posedge clk) begin
        if (buf_we && buf_gnt) mem[buf_addr] <= buf_wdata;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every granted write is compared against the expected queue.
    task automatic sb_loop();
        logic [13:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (buf_we && buf_gnt) begin
                wr_cnt++;
                if (sb_on) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL write_seq: got addr %0d data 0x%03h expected no write",
                                 buf_addr, buf_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({buf_addr, buf_wdata} !== e) begin
                            errors++;
                            $display("FAIL write_seq: got addr %0d data 0x%03h expected addr %0d data 0x%03h",
                                     buf_addr, buf_wdata, e[13:9], e[8:0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic exp_write(input int a, input logic [8:0] d);
        exp_q.push_back({5'(a), d});
        scr[a] = d;
    endtask

    task automatic exp_clear_all();
        for (int a = 0; a < 30; a++) exp_write(a, 9'h020);
    endtask

    task automatic exp_scroll();
        for (int a = 0; a < 20; a++) exp_write(a, scr[a + 10]);
        for (int a = 20; a < 30; a++) exp_write(a, 9'h020);
    endtask

    task automatic check_screen(input string name);
        for (int a = 0; a < 30; a++)
            check($sformatf("%s[%0d]", name, a), 32'(mem[a]), 32'(scr[a]));
    endtask

    // Offer one byte and return once it has been accepted.
    task automatic send(input logic [7:0] b, input logic [1:0] c, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_data  = b;
        color    = c;
        #1;
        while (!in_ready && waits < 100) begin
            step();
            waits++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 for byte 0x%02h", b);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic count_ready_low(output int n);
        n = 0;
        while (!in_ready && n < 500) begin
            n++;
            step();
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 500) begin
            n++;
            step();
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        count_busy(n);
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic do_clear();
        int w;
        int n;
        exp_clear_all();
        send(8'h0C, 2'd3, w);
        check("ff_cursor", {cur_row, cur_col}, 6'h00);
        count_busy(n);
        check("ff_busy_cycles", n, 31);
    endtask

    initial begin
        int w;
        int n;
        int wsum;
        int wr_before;
        logic [4:0] h_addr;
        logic [8:0] h_wdata;

        vecs[0]  = '{8'h41, 2'd2, 1'b1, 5'd0,  9'h141, 2'd0, 4'd1};
        vecs[1]  = '{8'h42, 2'd2, 1'b1, 5'd1,  9'h142, 2'd0, 4'd2};
        vecs[2]  = '{8'h08, 2'd0, 1'b0, 5'd0,  9'h000, 2'd0, 4'd1};
        vecs[3]  = '{8'h0D, 2'd0, 1'b0, 5'd0,  9'h000, 2'd0, 4'd0};
        vecs[4]  = '{8'h08, 2'd0, 1'b0, 5'd0,  9'h000, 2'd0, 4'd0};
        vecs[5]  = '{8'h78, 2'd1, 1'b1, 5'd0,  9'h0F8, 2'd0, 4'd1};
        vecs[6]  = '{8'hC1, 2'd3, 1'b1, 5'd1,  9'h1C1, 2'd0, 4'd2};
        vecs[7]  = '{8'h7F, 2'd1, 1'b0, 5'd0,  9'h000, 2'd0, 4'd2};
        vecs[8]  = '{8'h00, 2'd1, 1'b0, 5'd0,  9'h000, 2'd0, 4'd2};
        vecs[9]  = '{8'h63, 2'd0, 1'b1, 5'd2,  9'h063, 2'd0, 4'd3};
        vecs[10] = '{8'h08, 2'd0, 1'b0, 5'd0,  9'h000, 2'd0, 4'd2};
        vecs[11] = '{8'h0A, 2'd0, 1'b0, 5'd0,  9'h000, 2'd1, 4'd0};
        vecs[12] = '{8'h7A, 2'd1, 1'b1, 5'd10, 9'h0FA, 2'd1, 4'd1};
        vecs[13] = '{8'h1B, 2'd1, 1'b0, 5'd0,  9'h000, 2'd1, 4'd1};
        vecs[14] = '{8'h0A, 2'd0, 1'b0, 5'd0,  9'h000, 2'd2, 4'd0};
        vecs[15] = '{8'h7E, 2'd2, 1'b1, 5'd20, 9'h17E, 2'd2, 4'd1};
        vecs[16] = '{8'h0D, 2'd0, 1'b0, 5'd0,  9'h000, 2'd2, 4'd0};
        vecs[17] = '{8'h20, 2'd3, 1'b1, 5'd20, 9'h1A0, 2'd2, 4'd1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        color    = 2'd0;
        buf_gnt  = 1'b1;
        fork
            sb_loop();
        join_none

        // Reset values.
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("rst_in_ready_after", 32'(in_ready), 32'd1);
        check("rst_buf_we", 32'(buf_we), 32'd0);
        check("rst_buf_addr", 32'(buf_addr), 32'd0);
        check("rst_buf_wdata", 32'(buf_wdata), 32'd0);
        check("rst_buf_raddr", 32'(buf_raddr), 32'd0);
        check("rst_cursor", {cur_row, cur_col}, 6'h00);
        check("rst_busy", 32'(busy), 32'd0);

        // Clear screen from the home position.
        do_clear();
        check_screen("clear0");

        // Decode table, one byte per cycle.
        wsum = 0;
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].we) exp_write(int'(vecs[i].addr), vecs[i].wdata);
            send(vecs[i].b, vecs[i].c, w);
            wsum += w;
            check($sformatf("vec%0d_cursor", i), {cur_row, cur_col}, {vecs[i].row, vecs[i].col});
            check($sformatf("vec%0d_we", i), 32'(buf_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("vec%0d_addr", i), 32'(buf_addr), 32'(vecs[i].addr));
                check($sformatf("vec%0d_wdata", i), 32'(buf_wdata), 32'(vecs[i].wdata));
            end
        end
        check("vec_throughput_waits", wsum, 0);

        // LF on the last row at column 5 scrolls.
        for (int i = 0; i < 4; i++) begin
            exp_write(21 + i, {2'b00, 7'(8'h71 + i)});
            send(8'(8'h71 + i), 2'd0, w);
        end
        check("pre_lf_cursor", {cur_row, cur_col}, {2'd2, 4'd5});
        exp_scroll();
        send(8'h0A, 2'd0, w);
        check("lf_scroll_cursor", {cur_row, cur_col}, {2'd2, 4'd0});
        count_ready_low(n);
        check("lf_scroll_ready_low", n, 30);
        wait_idle("lf_scroll_idle");
        check_screen("lf_scroll");

        // Clear from a non-home cursor, then CR at (1,7).
        do_clear();
        send(8'h0A, 2'd0, w);
        check("cr_lf_cursor", {cur_row, cur_col}, {2'd1, 4'd0});
        check("cr_lf_no_we", 32'(buf_we), 32'd0);
        for (int i = 0; i < 7; i++) begin
            exp_write(10 + i, {2'b00, 7'(8'h30 + i)});
            send(8'(8'h30 + i), 2'd0, w);
        end
        check("cr_pre_cursor", {cur_row, cur_col}, {2'd1, 4'd7});
        send(8'h0D, 2'd0, w);
        check("cr_cursor", {cur_row, cur_col}, {2'd1, 4'd0});
        check("cr_no_we", 32'(buf_we), 32'd0);
        wait_idle("cr_idle");
        check_screen("cr");

        // Fill all 30 cells; the last one triggers a scroll.
        do_clear();
        wsum = 0;
        for (int i = 0; i < 30; i++) begin
            exp_write(i, {2'(i % 4), 7'(8'h61 + i)});
            if (i == 29) exp_scroll();
            send(8'(8'h61 + i), 2'(i % 4), w);
            wsum += w;
        end
        check("fill_throughput_waits", wsum, 0);
        check("fill_cursor", {cur_row, cur_col}, {2'd2, 4'd0});
        count_ready_low(n);
        check("fill_ready_low", n, 30);
        wait_idle("fill_idle");
        check_screen("fill_scroll");

        // Grant withheld while idle: write held, no byte accepted.
        exp_write(20, 9'h0D1);
        send(8'h51, 2'd1, w);
        buf_gnt  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h52;
        color    = 2'd2;
        #1;
        check("stall_idle_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_idle_we", 32'(buf_we), 32'd1);
            check("stall_idle_addr", 32'(buf_addr), 32'd20);
            check("stall_idle_wdata", 32'(buf_wdata), 32'h0D1);
            check("stall_idle_cursor", {cur_row, cur_col}, {2'd2, 4'd1});
        end
        buf_gnt = 1'b1;
        exp_write(21, 9'h152);
        send(8'h52, 2'd2, w);
        check("stall_idle_after_cursor", {cur_row, cur_col}, {2'd2, 4'd2});

        // Grant withheld for 3 cycles during scroll copy at k = 7.
        exp_scroll();
        send(8'h0A, 2'd0, w);
        check("stall_lf_cursor", {cur_row, cur_col}, {2'd2, 4'd0});
        n = 0;
        while (buf_raddr != 5'd17 && n < 100) begin
            step();
            n++;
        end
        check("stall_k7_raddr", 32'(buf_raddr), 32'd17);
        check("stall_k7_addr", 32'(buf_addr), 32'd6);
        h_addr  = buf_addr;
        h_wdata = buf_wdata;
        buf_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_scroll_we", 32'(buf_we), 32'd1);
            check("stall_scroll_addr", 32'(buf_addr), 32'(h_addr));
            check("stall_scroll_wdata", 32'(buf_wdata), 32'(h_wdata));
            check("stall_scroll_raddr", 32'(buf_raddr), 32'd17);
        end
        buf_gnt = 1'b1;
        wait_idle("stall_scroll_idle");
        check_screen("stall_scroll");
        check("pending_writes", exp_q.size(), 0);

        // Reset in the middle of a clear aborts it.
        sb_on = 1'b0;
        send(8'h0C, 2'd0, w);
        repeat (10) step();
        check("abort_pre_we", 32'(buf_we), 32'd1);
        rst = 1'b1;
        step();
        check("abort_we", 32'(buf_we), 32'd0);
        check("abort_ready_in_rst", 32'(in_ready), 32'd0);
        wr_before = wr_cnt;
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(in_ready), 32'd1);
        check("abort_cursor", {cur_row, cur_col}, 6'h00);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (5) step();
        check("abort_no_writes", wr_cnt, wr_before);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
